regfile_param: RTL and testbench

Parametrised successor to the fixed 32x32 integer register file. It has two combinational read ports and one synchronous write port. Width and depth are configurable, and register 0 can optionally be hardwired to zero. After reset, a sequencer sweeps every entry to zero, one per cycle, with a ready handshake, and illegal writes are flagged. It sits in the decode/writeback stage of the core datapath.

---
 rtl/regfile_param.sv | 68 ++++++
 tb/tb_regfile_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read/1-write register file with a post-reset clear sweep.
// Define RF_BYPASS_EN to forward an accepted write to matching read ports in the same cycle.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RAddr1_RF,
    input  logic [ADDR_W-1:0] RAddr2_RF,
    input  logic [ADDR_W-1:0] WAddr_RF,
    input  logic              WrEn_RF,
    input  logic [DATA_W-1:0] WD_RF,
    output logic [DATA_W-1:0] RD1_RF,
    output logic [DATA_W-1:0] RD2_RF,
    output logic              ready_RF,
    output logic              wr_err_RF
);
    localparam logic [ADDR_W:0]   NR   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              w_legal, wr_ok, r1_ok, r2_ok;
    // Same rule gates reads and writes: in range and not the hardwired zero entry.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NR) && !(ZERO_REG != 0 && a == '0);
    endfunction
    always_comb begin
        w_legal = legal(WAddr_RF);
        wr_ok   = WrEn_RF && ready_RF && w_legal;
        r1_ok   = ready_RF && legal(RAddr1_RF);
        r2_ok   = ready_RF && legal(RAddr2_RF);
        RD1_RF  = !r1_ok ? '0 : (BYP && wr_ok && RAddr1_RF == WAddr_RF) ? WD_RF : mem[RAddr1_RF];
        RD2_RF  = !r2_ok ? '0 : (BYP && wr_ok && RAddr2_RF == WAddr_RF) ? WD_RF : mem[RAddr2_RF];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            ready_RF  <= 1'b0;
            wr_err_RF <= 1'b0;
        end else begin
            wr_err_RF <= WrEn_RF && !(ready_RF && w_legal);
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == LAST) begin
                    state    <= RUN;
                    ready_RF <= 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (rst_n && wr_ok)
            mem[WAddr_RF] <= WD_RF;
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: random and directed checks of two regfile_param builds against a behavioural model.
// Instance 0 uses defaults; instance 1 has 24 entries and no hardwired zero register.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        rdy [2];
    logic        err [2];
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    int          cnt [2];
    logic [31:0] m [2][32];
    logic        err_e [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .RAddr1_RF(ra1), .RAddr2_RF(ra2), .WAddr_RF(wa),
        .WrEn_RF(we), .WD_RF(wd), .RD1_RF(rd1[0]), .RD2_RF(rd2[0]),
        .ready_RF(rdy[0]), .wr_err_RF(err[0]));

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .RAddr1_RF(ra1), .RAddr2_RF(ra2), .WAddr_RF(wa),
        .WrEn_RF(we), .WD_RF(wd), .RD1_RF(rd1[1]), .RD2_RF(rd2[1]),
        .ready_RF(rdy[1]), .wr_err_RF(err[1]));

    function automatic int nregs(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic bit legal(input int i, input logic [4:0] a);
        return (int'(a) < nregs(i)) && !(i == 0 && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
        if (cnt[i] < nregs(i) || !legal(i, a)) return 32'h0;
        if (BYP && we && legal(i, wa) && a == wa) return wd;
        return m[i][a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit c);
        #2;
        if (c)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rd1[%0d] a=%0d", i, ra1), rd1[i], exp_rd(i, ra1));
                chk($sformatf("rd2[%0d] a=%0d", i, ra2), rd2[i], exp_rd(i, ra2));
                chk($sformatf("ready[%0d]", i), {31'b0, rdy[i]}, {31'b0, cnt[i] >= nregs(i)});
                chk($sformatf("wr_err[%0d]", i), {31'b0, err[i]}, {31'b0, err_e[i]});
            end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                cnt[i]   = 0;
                err_e[i] = 1'b0;
                for (int j = 0; j < 32; j++) m[i][j] = 32'h0;
            end else begin
                err_e[i] = we && !(cnt[i] >= nregs(i) && legal(i, wa));
                if (we && cnt[i] >= nregs(i) && legal(i, wa)) m[i][wa] = wd;
                if (cnt[i] < nregs(i)) cnt[i]++;
            end
        end
        #1;
    endtask

    initial begin
        we = 1'b0; wa = '0; ra1 = '0; ra2 = '0; wd = '0; rst_n = 1'b0;
        tick(0);
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 34; k++) begin
            we  = (k >= 18 && k < 26);
            wa  = 5'(k);
            wd  = $urandom;
            ra1 = 5'(k);
            ra2 = 5'(31 - k);
            tick(1);
        end
        we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ra1 = 5'(k);
            ra2 = 5'(31 - k);
            tick(1);
        end
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd5;
        tick(1);
        we = 1'b0;
        tick(1);
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0; ra2 = 5'd0;
        tick(1);
        we = 1'b0;
        tick(1);
        tick(1);
        we = 1'b1; wa = 5'd27; wd = 32'hCAFEF00D; ra1 = 5'd27; ra2 = 5'd23;
        tick(1);
        we = 1'b0;
        tick(1);
        tick(1);
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; ra1 = 5'd9; ra2 = 5'd8;
        tick(1);
        we = 1'b0;
        tick(1);
        repeat (400) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom);
            wd  = $urandom;
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            tick(1);
        end
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; wa = 5'(k); wd = $urandom; ra1 = 5'(k - 1); ra2 = 5'(k);
            tick(1);
        end
        we = 1'b0; rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            we = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom;
            ra1 = 5'($urandom); ra2 = wa;
            tick(1);
        end
        rst_n = 1'b0; we = 1'b1;
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 36; k++) begin
            we = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom;
            ra1 = 5'(k); ra2 = wa;
            tick(1);
        end
        we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ra1 = 5'(k);
            ra2 = 5'(31 - k);
            tick(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
